pipe_stage_em: RTL and testbench

PIPE_STAGE_EM -- requirements
Module: pipe_stage_em

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/skid_buf_2.sv | 71 +++++++
 rtl/pipe_stage_em.sv | 93 +++++++++
 tb/tb_pipe_stage_em.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared EX/MEM stage types: payload struct, skid-buffer state encoding.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_pkg;

   localparam int EM_ADDR_W = 5;
   localparam int EM_DATA_W = 32;
   localparam int EM_F3_W   = 3;
   localparam int EM_OP_W   = 7;

   // Occupancy-named states: the state value doubles as the entry count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } em_state_t;

   // Everything EX hands to MEM for one instruction.
   typedef struct packed {
      logic                 reg_write;
      logic                 mem_write;
      logic                 mem_read;
      logic [1:0]           result_src;
      logic [EM_DATA_W-1:0] alu_result;
      logic [EM_DATA_W-1:0] write_data;
      logic [EM_DATA_W-1:0] pc_plus4;
      logic [EM_ADDR_W-1:0] rd;
      logic [EM_F3_W-1:0]   funct3;
      logic [EM_OP_W-1:0]   op;
   } em_payload_t;

   // Entries held in a given state.
   function automatic logic [1:0] occ_of(em_state_t s);
      case (s)
         ONE:     occ_of = 2'd1;
         TWO:     occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic two-entry skid buffer (main entry drives the output, skid absorbs one extra).
// Latency: 1 cycle from accept to output when empty, or when one entry is consumed alongside.
// Backpressure: in_rdy is a pure state decode (low only when both entries full); clr empties it.
module skid_buf_2
   import pipe_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [1:0]   occ
);

   em_state_t    state;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         accept;
   logic         consume;

   assign in_rdy  = (state != TWO);
   assign out_vld = (state != EMPTY);
   assign occ     = occ_of(state);
   assign out_dat = main_q;
   assign accept  = in_vld & in_rdy;
   assign consume = out_vld & out_rdy;

   // Occupancy FSM; main is never cleared except by reset so data holds when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (clr) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_q <= in_dat;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_q <= in_dat;
               end else if (accept) begin
                  skid_q <= in_dat;
                  state  <= TWO;
               end else if (consume) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (consume) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/pipe_stage_em.sv
// EX/MEM pipeline register with a two-entry skid buffer, flush, and bubble gating of writes.
// Latency: 1 cycle EX accept to *M when empty or when MEM consumes in the same cycle.
// Backpressure: ReadyE drops only when both entries are held; never combinational on ReadyM.
module pipe_stage_em
   import pipe_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int FUNCT3_WIDTH  = 3,
   parameter int OP_WIDTH      = 7
) (
   input  logic                     CLK,
   input  logic                     RST_N,
   input  logic                     FlushM,
   input  logic                     ValidE,
   output logic                     ReadyE,
   input  logic                     RegWriteE,
   input  logic                     MemWriteE,
   input  logic                     MemReadE,
   input  logic [1:0]               ResultSrcE,
   input  logic [DATA_WIDTH-1:0]    ALUResultE,
   input  logic [DATA_WIDTH-1:0]    WriteDataE,
   input  logic [DATA_WIDTH-1:0]    PCPlus4E,
   input  logic [ADDRESS_WIDTH-1:0] RdE,
   input  logic [FUNCT3_WIDTH-1:0]  funct3E,
   input  logic [OP_WIDTH-1:0]      opE,
   output logic                     ValidM,
   input  logic                     ReadyM,
   output logic                     RegWriteM,
   output logic                     MemWriteM,
   output logic                     MemReadM,
   output logic [1:0]               ResultSrcM,
   output logic [DATA_WIDTH-1:0]    ALUResultM,
   output logic [DATA_WIDTH-1:0]    WriteDataM,
   output logic [ADDRESS_WIDTH-1:0] RdM,
   output logic [DATA_WIDTH-1:0]    PCPlus4M,
   output logic [FUNCT3_WIDTH-1:0]  funct3M,
   output logic [OP_WIDTH-1:0]      opM,
   output logic [1:0]               OccM
);

   localparam int PW = $bits(em_payload_t);

   em_payload_t pay_in;
   em_payload_t pay_out;
   logic        buf_vld;

   // Pack the EX fields into the shared payload layout.
   always_comb begin
      pay_in            = '0;
      pay_in.reg_write  = RegWriteE;
      pay_in.mem_write  = MemWriteE;
      pay_in.mem_read   = MemReadE;
      pay_in.result_src = ResultSrcE;
      pay_in.alu_result = EM_DATA_W'(ALUResultE);
      pay_in.write_data = EM_DATA_W'(WriteDataE);
      pay_in.pc_plus4   = EM_DATA_W'(PCPlus4E);
      pay_in.rd         = EM_ADDR_W'(RdE);
      pay_in.funct3     = EM_F3_W'(funct3E);
      pay_in.op         = EM_OP_W'(opE);
   end

   // Flush clears occupancy at the edge, winning over any accept/consume that cycle.
   skid_buf_2 #(.W(PW)) u_skid (
      .clk     (CLK),
      .rst_n   (RST_N),
      .clr     (FlushM),
      .in_vld  (ValidE),
      .in_rdy  (ReadyE),
      .in_dat  (pay_in),
      .out_vld (buf_vld),
      .out_rdy (ReadyM),
      .out_dat (pay_out),
      .occ     (OccM)
   );

   assign ValidM = buf_vld;

   // Write-type controls are qualified by ValidM so a bubble can never write.
   assign RegWriteM = pay_out.reg_write & buf_vld;
   assign MemWriteM = pay_out.mem_write & buf_vld;
   assign MemReadM  = pay_out.mem_read  & buf_vld;

   // Data fields pass straight through and therefore hold while empty.
   assign ResultSrcM = pay_out.result_src;
   assign ALUResultM = DATA_WIDTH'(pay_out.alu_result);
   assign WriteDataM = DATA_WIDTH'(pay_out.write_data);
   assign PCPlus4M   = DATA_WIDTH'(pay_out.pc_plus4);
   assign RdM        = ADDRESS_WIDTH'(pay_out.rd);
   assign funct3M    = FUNCT3_WIDTH'(pay_out.funct3);
   assign opM        = OP_WIDTH'(pay_out.op);

endmodule

// File: tb/tb_pipe_stage_em.sv
// Self-checking bench for pipe_stage_em: queue model plus directed literal checks.
// Latency: model predicts *M one cycle after each accepted instruction.
// Backpressure: exercised via ReadyM stalls, held ValidE while full, and flush.
module tb_pipe_stage_em;
   import pipe_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        FlushM = 1'b0;
   logic        ValidE = 1'b0;
   logic        ReadyE;
   logic        RegWriteE = 1'b0, MemWriteE = 1'b0, MemReadE = 1'b0;
   logic [1:0]  ResultSrcE = '0;
   logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0;
   logic [4:0]  RdE = '0;
   logic [2:0]  funct3E = '0;
   logic [6:0]  opE = '0;
   logic        ValidM;
   logic        ReadyM = 1'b0;
   logic        RegWriteM, MemWriteM, MemReadM;
   logic [1:0]  ResultSrcM;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic [2:0]  funct3M;
   logic [6:0]  opM;
   logic [1:0]  OccM;

   int n_chk  = 0;
   int n_fail = 0;

   pipe_stage_em dut (
      .CLK(CLK), .RST_N(RST_N), .FlushM(FlushM), .ValidE(ValidE), .ReadyE(ReadyE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemReadE(MemReadE),
      .ResultSrcE(ResultSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
      .PCPlus4E(PCPlus4E), .RdE(RdE), .funct3E(funct3E), .opE(opE),
      .ValidM(ValidM), .ReadyM(ReadyM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .MemReadM(MemReadM), .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M), .funct3M(funct3M),
      .opM(opM), .OccM(OccM)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: an in-order FIFO of at most two instructions, plus the
   // last instruction that was at the head (what the data outputs keep showing).
   em_payload_t q[$];
   em_payload_t shown = '0;

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q.delete();
         shown = '0;
      end else begin
         em_payload_t p;
         bit acc, con;
         p = '{RegWriteE, MemWriteE, MemReadE, ResultSrcE, ALUResultE, WriteDataE,
               PCPlus4E, RdE, funct3E, opE};
         acc = ValidE && (q.size() < 2);
         con = (q.size() > 0) && ReadyM;
         if (FlushM) begin
            q.delete();
         end else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back(p);
         end
         if (q.size() > 0) shown = q[0];
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge CLK) begin
      bit v;
      v = (q.size() > 0);
      chk("m_valid",  ValidM, v);
      chk("m_occ",    OccM, q.size());
      chk("m_ready",  ReadyE, q.size() < 2);
      chk("m_regwr",  RegWriteM, v && shown.reg_write);
      chk("m_memwr",  MemWriteM, v && shown.mem_write);
      chk("m_memrd",  MemReadM,  v && shown.mem_read);
      chk("m_rsrc",   ResultSrcM, shown.result_src);
      chk("m_alu",    ALUResultM, shown.alu_result);
      chk("m_wdata",  WriteDataM, shown.write_data);
      chk("m_pc4",    PCPlus4M, shown.pc_plus4);
      chk("m_rd",     RdM, shown.rd);
      chk("m_f3",     funct3M, shown.funct3);
      chk("m_op",     opM, shown.op);
   end

   // Drive one EX instruction; other fields derived from the ALU value.
   task automatic drive(input logic v, input logic [31:0] alu,
                        input logic rw, input logic mw, input logic mr);
      ValidE     = v;
      ALUResultE = alu;
      WriteDataE = ~alu;
      PCPlus4E   = alu * 4 + 32'h100;
      RdE        = alu[4:0];
      funct3E    = alu[2:0];
      opE        = alu[6:0] ^ 7'h33;
      ResultSrcE = alu[1:0];
      RegWriteE  = rw;
      MemWriteE  = mw;
      MemReadE   = mr;
   endtask

   task automatic cyc();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      // Reset held across a few edges.
      @(negedge CLK);
      chk("rst_ready", ReadyE, 1'b1);
      chk("rst_valid", ValidM, 1'b0);
      chk("rst_alu",   ALUResultM, 32'h0);
      cyc();
      RST_N = 1'b1;

      // Streaming: 1..8 back to back, each visible one cycle after accept.
      ReadyM = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, i, 1'b1, 1'b0, i[0]);
         cyc();
         chk("stream_alu", ALUResultM, i);
         chk("stream_occ", OccM, 2'd1);
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("drain_valid", ValidM, 1'b0);
      chk("hold_alu",    ALUResultM, 32'd8);

      // Backpressure: A then B stall, a held offer while full is ignored.
      ReadyM = 1'b0;
      drive(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
      cyc();
      chk("bp_occ1", OccM, 2'd1);
      drive(1'b1, 32'h20, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("bp_occ2",   OccM, 2'd2);
      chk("bp_ready",  ReadyE, 1'b0);
      chk("bp_head",   ALUResultM, 32'h10);
      drive(1'b1, 32'h99, 1'b1, 1'b1, 1'b1);
      cyc();
      chk("bp_full_hold", ALUResultM, 32'h10);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      ReadyM = 1'b1;
      cyc();
      chk("bp_b_alu",  ALUResultM, 32'h20);
      chk("bp_b_mw",   MemWriteM, 1'b1);
      cyc();
      chk("bp_empty",  ValidM, 1'b0);

      // Flush in TWO with a concurrent offer: C is dropped.
      ReadyM = 1'b0;
      drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("fl_occ2", OccM, 2'd2);
      drive(1'b1, 32'h30, 1'b1, 1'b1, 1'b0);
      FlushM = 1'b1;
      ReadyM = 1'b1;
      cyc();
      FlushM = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("fl_occ",   OccM, 2'd0);
      chk("fl_valid", ValidM, 1'b0);
      chk("fl_alu",   ALUResultM, 32'h11);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("fl_no_c", ValidM, 1'b0);
      end

      // Gating: write controls offered without ValidE never reach M.
      drive(1'b0, 32'h5, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("gate_rw", RegWriteM, 1'b0);
         chk("gate_mw", MemWriteM, 1'b0);
      end

      // Simultaneous accept and consume in ONE.
      drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      cyc();
      drive(1'b1, 32'h41, 1'b0, 1'b1, 1'b0);
      cyc();
      chk("sim_occ", OccM, 2'd1);
      chk("sim_alu", ALUResultM, 32'h41);
      chk("sim_mw",  MemWriteM, 1'b1);

      // Mid-stream reset with two entries held.
      ReadyM = 1'b0;
      drive(1'b1, 32'h50, 1'b1, 1'b1, 1'b0);
      cyc();
      cyc();
      chk("pre_rst_occ", OccM, 2'd2);
      #2 RST_N = 1'b0;
      #1;
      chk("arst_occ",   OccM, 2'd0);
      chk("arst_valid", ValidM, 1'b0);
      chk("arst_ready", ReadyE, 1'b1);
      chk("arst_rw",    RegWriteM, 1'b0);
      chk("arst_alu",   ALUResultM, 32'h0);
      cyc();
      chk("in_rst_ready", ReadyE, 1'b1);
      RST_N = 1'b1;
      ReadyM = 1'b1;
      drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
      cyc();
      chk("post_rst_alu", ALUResultM, 32'h55);
      chk("post_rst_mr",  MemReadM, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      cyc();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
